// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between a word memory and an x86 decoder.
//
// Issues sequential word-aligned 32-bit reads, one outstanding at a time. It packs the
// returned bytes into a circular byte queue and presents the next 4 stream bytes
// (oldest in [7:0]) to the decoder. The decoder retires 1-4 bytes per cycle. A redirect
// flushes the queue and restarts fetch at any byte address.
//
// Optional feature: define FETCH_STATS_EN to enable the fetch/stall statistics counters.
// When it is undefined, both counter outputs are tied to 0.
//
// Ports:
//   i_clk, i_reset                         clock, asynchronous active-low reset
//   o_mem_address/o_mem_cmd/o_mem_valid    read request (word aligned)
//   i_mem_ready                            memory accepts the request
//   i_mem_res_valid/i_mem_data             read response
//   o_mem_res_ready                        always 1
//   o_valid/o_data/o_pc                    decoder window (>= 4 bytes) and its byte address
//   i_consume/i_consume_size               retire size+1 bytes
//   i_redirect/i_redirect_addr             flush and restart fetch
//   o_fetch_count/o_stall_count            statistics
module fetch_queue #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              QUEUE_BYTES   = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDR    = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic                     o_mem_cmd,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  input  logic                     i_mem_res_valid,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic                     o_mem_res_ready,
  output logic                     o_valid,
  output logic [31:0]              o_data,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  input  logic                     i_consume,
  input  logic [1:0]               i_consume_size,
  input  logic                     i_redirect,
  input  logic [ADDRESS_WIDTH-1:0] i_redirect_addr,
  output logic [31:0]              o_fetch_count,
  output logic [31:0]              o_stall_count
);

  localparam int unsigned PtrW = $clog2(QUEUE_BYTES);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic        MEM_CMD_READ = 1'b0;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

  state_e                   r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [1:0]               r_skip;
  logic [PtrW-1:0]          r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]          r_cnt, w_cnt_next;
  logic [7:0]               r_q [QUEUE_BYTES];

  logic                     w_space_ok;
  logic                     w_fill;
  logic                     w_cons;
  logic [2:0]               w_fill_n;
  logic [2:0]               w_cons_n;
  logic [3:0]               w_wr_en;
  logic [PtrW-1:0]          w_wr_idx [4];

  assign o_mem_cmd       = MEM_CMD_READ;
  assign o_mem_res_ready = 1'b1;
  assign o_mem_address   = r_mem_addr;
  assign o_mem_valid     = (r_state == StReq);
  assign o_pc            = r_pc;
  assign o_valid         = (r_cnt >= CntW'(4));

  // Space is only checked at issue; consumption can only add space before the fill lands.
  assign w_space_ok = (r_cnt <= CntW'(QUEUE_BYTES - 4));
  assign w_fill     = (r_state == StWait) && i_mem_res_valid && !i_redirect;
  assign w_cons     = i_consume && o_valid && !i_redirect;
  assign w_fill_n   = 3'd4 - {1'b0, r_skip};
  assign w_cons_n   = {1'b0, i_consume_size} + 3'd1;

  // A response always retires the outstanding request, even when it coincides with a
  // redirect; otherwise DISCARD would wait for a response that never comes.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (!i_redirect && w_space_ok) w_state_next = StReq;
      StReq: begin
        if (i_redirect)       w_state_next = StIdle;
        else if (i_mem_ready) w_state_next = StWait;
      end
      StWait: begin
        if (i_mem_res_valid) w_state_next = StIdle;
        else if (i_redirect) w_state_next = StDiscard;
      end
      StDiscard: if (i_mem_res_valid) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_cons) w_cnt_next = w_cnt_next - CntW'(w_cons_n);
    if (w_fill) w_cnt_next = w_cnt_next + CntW'(w_fill_n);
  end

  // Byte k of the returned word lands at wr_ptr + k - skip; skipped bytes are not written.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wr_en[k]  = w_fill && (3'(k) >= {1'b0, r_skip});
      w_wr_idx[k] = r_wr_ptr + PtrW'(k) - PtrW'(r_skip);
    end
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (o_valid) o_data[8*k +: 8] = r_q[r_rd_ptr + PtrW'(k)];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_mem_addr <= {RESET_ADDR[ADDRESS_WIDTH-1:2], 2'b00};
      r_skip     <= RESET_ADDR[1:0];
      r_pc       <= RESET_ADDR;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_redirect) begin
        r_mem_addr <= {i_redirect_addr[ADDRESS_WIDTH-1:2], 2'b00};
        r_skip     <= i_redirect_addr[1:0];
        r_pc       <= i_redirect_addr;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_cnt      <= '0;
      end else begin
        r_cnt <= w_cnt_next;
        if (w_cons) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(w_cons_n);
          r_pc     <= r_pc + ADDRESS_WIDTH'(w_cons_n);
        end
        if (w_fill) begin
          r_wr_ptr   <= r_wr_ptr + PtrW'(w_fill_n);
          r_mem_addr <= r_mem_addr + ADDRESS_WIDTH'(4);
          r_skip     <= 2'd0;
        end
      end
    end
  end

  // Queue storage needs no reset: o_data is gated by o_valid.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_wr_en[k]) r_q[w_wr_idx[k]] <= i_mem_data[8*k +: 8];
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count, r_stall_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_fill)                  r_fetch_count <= r_fetch_count + 32'd1;
      if (!o_valid && !i_redirect) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
  assign o_stall_count = r_stall_count;
`else
  assign o_fetch_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int unsigned LAT = 3;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] o_mem_address;
  logic        o_mem_cmd;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_res_valid = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        o_mem_res_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic [31:0] o_pc;
  logic        i_consume = 1'b0;
  logic [1:0]  i_consume_size = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_addr = '0;
  logic [31:0] o_fetch_count;
  logic [31:0] o_stall_count;

  fetch_queue dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .o_mem_address   (o_mem_address),
    .o_mem_cmd       (o_mem_cmd),
    .o_mem_valid     (o_mem_valid),
    .i_mem_ready     (i_mem_ready),
    .i_mem_res_valid (i_mem_res_valid),
    .i_mem_data      (i_mem_data),
    .o_mem_res_ready (o_mem_res_ready),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_pc            (o_pc),
    .i_consume       (i_consume),
    .i_consume_size  (i_consume_size),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_fetch_count   (o_fetch_count),
    .o_stall_count   (o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } win_t;

  win_t        exp_win[$];
  logic [31:0] exp_req[$];
  int          total = 0;
  int          bad = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_pend_addr = '0;
  int          mem_lat = 0;
  int          cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Memory: byte at address a holds a[7:0]; responds LAT negedges after acceptance.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      i_mem_res_valid = 1'b0;
      if (mem_pend) begin
        mem_lat--;
        if (mem_lat == 0) begin
          i_mem_res_valid = 1'b1;
          i_mem_data = {8'(mem_pend_addr + 3), 8'(mem_pend_addr + 2),
                        8'(mem_pend_addr + 1), 8'(mem_pend_addr)};
          mem_pend = 1'b0;
        end
      end
      i_mem_ready = (cyc % 3) != 0;
      if (i_reset && o_mem_valid && i_mem_ready) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got 0x%08h expected none", o_mem_address);
        end else begin
          check("req_addr", o_mem_address, exp_req.pop_front());
        end
        mem_pend = 1'b1;
        mem_pend_addr = o_mem_address;
        mem_lat = LAT;
      end
    end
  end

  // Monitor: every window the decoder retires is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge i_clk);
      #3;
      if (o_valid && i_consume && !i_redirect) begin
        if (exp_win.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_consume: got pc 0x%08h expected none", o_pc);
        end else begin
          win_t w;
          w = exp_win.pop_front();
          check("win_pc", o_pc, w.pc);
          check("win_data", o_data, w.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge i_clk);
    #2;
  endtask

  task automatic settle();
    repeat (60) step();
  endtask

  task automatic consume(input logic [1:0] size, input logic [31:0] pc, input logic [31:0] data);
    int n;
    n = 0;
    exp_win.push_back('{pc: pc, data: data});
    while (!o_valid && n < 200) begin
      step();
      n++;
    end
    if (!o_valid) begin
      void'(exp_win.pop_back());
      total++;
      bad++;
      $display("FAIL valid_timeout: got o_valid 0 expected 1");
    end else begin
      i_consume = 1'b1;
      i_consume_size = size;
      step();
      i_consume = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    check("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    check("rst_mem_addr", o_mem_address, 32'h0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", o_data, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_fetch_cnt", o_fetch_count, 32'h0);
    check("rst_res_ready", 32'(o_mem_res_ready), 32'd1);

    // Fill without consuming: exactly 4 requests, then the queue is full.
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    i_reset = 1'b1;
    repeat (80) step();
    check("full_req_left", 32'(exp_req.size()), 32'd0);
    check("full_mem_valid", 32'(o_mem_valid), 32'd0);
    check("full_valid", 32'(o_valid), 32'd1);
    check("full_pc", o_pc, 32'h0);
    check("full_data", o_data, 32'h03020100);

    exp_req.push_back(32'h10);
    exp_req.push_back(32'h14);
    consume(2'd0, 32'h0, 32'h03020100);
    consume(2'd1, 32'h1, 32'h04030201);
    consume(2'd0, 32'h3, 32'h06050403);
    consume(2'd3, 32'h4, 32'h07060504);
    settle();
    check("a_req_left", 32'(exp_req.size()), 32'd0);
    check("a_pc", o_pc, 32'h8);

    // Redirect to 0x102 while the read of 24 is in flight.
    exp_req.push_back(32'h18);
    consume(2'd3, 32'h8, 32'h0B0A0908);
    n = 0;
    while (!mem_pend && n < 200) begin
      step();
      n++;
    end
    check("wait_pend", 32'(mem_pend), 32'd1);
    step();
    i_redirect = 1'b1;
    i_redirect_addr = 32'h102;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h10C);
    step();
    i_redirect = 1'b0;
    check("b_pc_redir", o_pc, 32'h102);
    settle();
    check("b_req_left", 32'(exp_req.size()), 32'd0);
    check("b_pc", o_pc, 32'h102);
    check("b_data", o_data, 32'h05040302);
    exp_req.push_back(32'h110);
    consume(2'd3, 32'h102, 32'h05040302);

    // Redirect, consume and response in the same cycle.
    n = 0;
    while (!(i_mem_res_valid && o_valid) && n < 200) begin
      step();
      n++;
    end
    check("wait_resp", 32'(i_mem_res_valid && o_valid), 32'd1);
    i_redirect = 1'b1;
    i_redirect_addr = 32'h203;
    i_consume = 1'b1;
    i_consume_size = 2'd3;
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    exp_req.push_back(32'h208);
    exp_req.push_back(32'h20C);
    step();
    i_redirect = 1'b0;
    i_consume = 1'b0;
    check("c_valid", 32'(o_valid), 32'd0);
    check("c_pc", o_pc, 32'h203);
    settle();
    check("c_req_left", 32'(exp_req.size()), 32'd0);
    check("c_data", o_data, 32'h06050403);

    exp_req.push_back(32'h210);
    consume(2'd3, 32'h203, 32'h06050403);
    settle();
    check("d_req_left", 32'(exp_req.size()), 32'd0);
    check("d_win_left", 32'(exp_win.size()), 32'd0);
    check("d_pc", o_pc, 32'h207);
    check("d_data", o_data, 32'h0A090807);
    check("d_mem_addr", o_mem_address, 32'h214);

`ifdef FETCH_STATS_EN
    check("fetch_count", o_fetch_count, 32'd15);
`else
    check("fetch_count", o_fetch_count, 32'd0);
    check("stall_count", o_stall_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end between the word-oriented `memory` block and the x86 `decoder`. It acts as the memory initiator: it issues sequential 32-bit read requests, packs the returned bytes into a byte-granular prefetch queue, and presents a 4-byte little-endian window to the decoder. The decoder retires 1–4 bytes per instruction, and the block supports redirection of the fetch stream to any byte address.

## Interface
- `ADDRESS_WIDTH`, 32: memory address width.
- `DATA_WIDTH`, 32: memory word width. Only 32 is supported.
- `QUEUE_BYTES`, 16: prefetch queue depth in bytes. Power of two, ≥ 8.
- `RESET_ADDR`, 0: first fetch byte address after reset.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `o_mem_address`  out  ADDRESS_WIDTH  word-aligned read address (bits [1:0] = 0).
- `o_mem_cmd`  out  1  constant `MEM_CMD_READ`.
- `o_mem_valid`  out  1  request valid.
- `i_mem_ready`  in  1  memory can accept a request.
- `i_mem_res_valid`  in  1  read data valid.
- `i_mem_data`  in  DATA_WIDTH  read data; byte 0 is bits [7:0].
- `o_mem_res_ready`  out  1  constant 1.
- `o_valid`  out  1  `o_data` holds ≥ 4 valid bytes.
- `o_data`  out  32  next 4 stream bytes; the oldest byte is in [7:0].
- `o_pc`  out  ADDRESS_WIDTH  byte address of `o_data[7:0]`.
- `i_consume`  in  1  retire bytes this cycle. Legal only while `o_valid` is high.
- `i_consume_size`  in  2  bytes retired minus 1 (0→1 byte … 3→4 bytes).
- `i_redirect`  in  1  flush and restart fetch at `i_redirect_addr`.
- `i_redirect_addr`  in  ADDRESS_WIDTH  new byte address; any alignment is allowed.
- `o_fetch_count`, `o_stall_count`  out  32 each  statistics counters (see Configuration).

## Operation
- The queue is a circular byte buffer with read pointer, write pointer and byte count `cnt` (0..QUEUE_BYTES). Pointers wrap modulo QUEUE_BYTES.
- Request FSM states:
  - IDLE → REQ when free space (QUEUE_BYTES − cnt) ≥ 4 and no redirect is present.
  - REQ: `o_mem_valid` = 1. Moves to WAIT on the cycle where `o_mem_valid && i_mem_ready`.
  - WAIT: `o_mem_valid` = 0. On `i_mem_res_valid`, the 4 bytes are written to the queue, `o_mem_address` += 4, and the FSM returns to IDLE.
  - DISCARD: entered from WAIT on redirect. The next `i_mem_res_valid` is dropped and the FSM goes to IDLE.
- At most one request is outstanding at a time. Space is checked only at issue; consumption can only add space, so a returning word never overflows the queue.
- Skip count: after a redirect, the first returned word loses its low `i_redirect_addr[1:0]` bytes. Only 4 − skip bytes are written.
- Consume: `cnt` -= size+1, the read pointer advances by size+1, and `o_pc` += size+1. A fill in the same cycle gives a net `cnt` update of −(size+1) + (4 − skip).
- Redirect (highest priority over consume and fill in the same cycle):
  - `cnt` ← 0 and both pointers ← 0.
  - `o_pc` ← `i_redirect_addr`; `o_mem_address` ← {`i_redirect_addr`[31:2], 2'b00}; skip ← `i_redirect_addr[1:0]`.
  - FSM goes REQ→IDLE (the request is abandoned if not yet accepted), WAIT→DISCARD, IDLE→IDLE, DISCARD→DISCARD.
  - A response arriving in the same cycle as a redirect is dropped.
- `o_valid` = (cnt ≥ 4). `o_data` is driven combinationally from the queue at the read pointer. It is 0 when `o_valid` = 0.

## Timing
- Reset values:
  - `o_mem_valid` 0, `o_mem_address` {RESET_ADDR[31:2], 2'b00}, skip RESET_ADDR[1:0], FSM IDLE.
  - `cnt` 0, `o_valid` 0, `o_data` 0, `o_pc` RESET_ADDR, counters 0.
- Reset may assert mid-transaction. A response arriving after reset is released while the FSM is in IDLE/REQ is ignored.
- Startup latency, reset release to first `o_valid` with memory latency L: IDLE (1 cycle) + REQ accept (1) + L + write (1). `o_valid` rises the cycle after the response.
- Steady state: one word per (3 + L) cycles.
- `o_valid` with 4 ≤ cnt < 8: a 4-byte consume drops `o_valid` the next cycle unless a fill lands in the same cycle.

## Configuration
- `FETCH_STATS_EN` defined:
  - `o_fetch_count` increments on each accepted response; dropped responses are not counted.
  - `o_stall_count` increments each cycle with `o_valid` = 0 and `i_redirect` = 0.
  - Both counters wrap at 2^32 and are cleared by reset.
- Not defined: both outputs are constant 0 and the counter logic is omitted.

## Test plan
- Reset with RESET_ADDR=0 and memory words 0x03020100, 0x07060504 → first request address 0; `o_valid` rises with `o_data`=0x03020100, `o_pc`=0.
- Consume sizes 1,2,1 back-to-back → `o_pc` 1, 3, 4; `o_data` 0x04030201, 0x06050403, 0x07060504.
- No consumes, QUEUE_BYTES=16 → exactly 4 requests (addresses 0,4,8,12), then `o_mem_valid` stays 0 with cnt=16; one 4-byte consume → next request to 16.
- Redirect to 0x102 while in WAIT → the in-flight response is discarded, the next request goes to 0x100, the first window is bytes 0x102..0x105, and `o_pc`=0x102.
- Redirect, consume and response in the same cycle → cnt=0 afterward, the response is dropped, and `o_pc`=redirect address.
- `FETCH_STATS_EN` defined, 3 words fetched then 1 discarded → `o_fetch_count`=3.
